// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multdiv sequencer and the pipeline bypass/stall logic.
// Holds the mul/div ALU opcodes, the sequencer state encoding and the exception defaults.
package multdiv_sequencer_pkg;

  localparam logic [4:0]  ALU_OP_MUL = 5'b00110;
  localparam logic [4:0]  ALU_OP_DIV = 5'b00111;

  localparam int          DEF_TIMEOUT_CYCLES = 64;
  localparam logic [4:0]  DEF_STATUS_REG     = 5'd30;
  localparam logic [31:0] DEF_MUL_EXC_CODE   = 32'd4;
  localparam logic [31:0] DEF_DIV_EXC_CODE   = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_WB    = 2'd3
  } md_state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_t;

  function automatic logic [4:0] alu_op_of(input md_op_t op);
    return (op == OP_DIV) ? ALU_OP_DIV : ALU_OP_MUL;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_watchdog.sv
// Watchdog for the multdiv unit: counts BUSY cycles since the start pulse.
// terminal is raised during the TIMEOUT_CYCLES-th enabled cycle after a clear.
module md_watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one mul/div through the shared multdiv unit: capture, start pulse,
// wait for ready (or watchdog), then hold the writeback payload until acknowledged.
//
// state    | meaning
// ST_IDLE  | no op in flight; accepts exactly one of issue_mul/issue_div
// ST_START | one-cycle start pulse to multdiv, watchdog cleared
// ST_BUSY  | waiting for md_ready or watchdog terminal count
// ST_WB    | payload presented to writeback until wb_ack
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [4:0]  STATUS_REG     = DEF_STATUS_REG,
  parameter logic [31:0] MUL_EXC_CODE   = DEF_MUL_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE   = DEF_DIV_EXC_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mul,
  input  logic        issue_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        abort,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  input  logic        wb_ack
);

  md_state_t   state, state_d;
  md_op_t      op_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        issue;
  logic        wd_terminal;

  assign issue = issue_mul ^ issue_div;

  md_watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ST_START),
    .enable  (state == ST_BUSY),
    .terminal(wd_terminal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (issue) state_d = ST_START;
      ST_START: state_d = ST_BUSY;
      ST_BUSY:  if (md_ready || wd_terminal) state_d = ST_WB;
      ST_WB:    if (wb_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // md_ready in BUSY wins over a coincident watchdog terminal count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_MUL;
      rd_q     <= '0;
      md_a     <= '0;
      md_b     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (!abort) begin
      if (state == ST_IDLE && issue) begin
        op_q <= issue_div ? OP_DIV : OP_MUL;
        rd_q <= issue_rd;
        md_a <= operand_a;
        md_b <= operand_b;
      end
      if (state == ST_BUSY) begin
        if (md_ready) begin
          result_q <= md_result;
          exc_q    <= md_exception;
        end else if (wd_terminal) begin
          result_q <= '0;
          exc_q    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    wb_valid     = 1'b0;
    wb_exception = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    busy         = (state != ST_IDLE);
    stall        = 1'b0;
    unique case (state)
      ST_IDLE:  stall = issue;
      ST_START: stall = 1'b1;
      ST_BUSY:  stall = 1'b1;
      ST_WB:    stall = !wb_ack;
      default:  stall = 1'b0;
    endcase
    if (state == ST_START && !abort) begin
      md_ctrl_mult = (op_q == OP_MUL);
      md_ctrl_div  = (op_q == OP_DIV);
    end
    if (state == ST_WB && !abort) begin
      wb_valid     = 1'b1;
      wb_exception = exc_q;
      wb_rd        = exc_q ? STATUS_REG : rd_q;
      wb_data      = exc_q ? ((op_q == OP_DIV) ? DIV_EXC_CODE : MUL_EXC_CODE) : result_q;
    end
  end

endmodule
